// File: rtl/minimips_ctrl_pkg.sv
// Shared definitions for the MiniMips multi-cycle control path:
// state encoding, ALU operation codes and ALU B-operand selects.
package minimips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    MEM_WB   = 4'd6,
    MEM_WR   = 4'd7,
    ALU_WB   = 4'd8,
    BRANCH   = 4'd9
  } mcState_t;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;

  localparam logic [1:0] SRCB_RT  = 2'b00;
  localparam logic [1:0] SRCB_ONE = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

endpackage

// File: rtl/mc_output_decode.sv
// Combinational control-output decode for the multi-cycle controller.
// Moore on state, except the mem_ready-qualified fetch strobes and store retire.
module mc_output_decode
  import minimips_ctrl_pkg::*;
(
  input  mcState_t   state,
  input  logic       isRtype,
  input  logic       isBne,
  input  logic [1:0] ialuCode,
  input  logic       memReady,
  input  logic       decodeIllegal,
  output logic       pcWrite,
  output logic       irWrite,
  output logic       iOrD,
  output logic       memRead,
  output logic       memWrite,
  output logic       regDst,
  output logic       regWrite,
  output logic       memToReg,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [2:0] aluOp,
  output logic       branch,
  output logic       branchNot,
  output logic       instrDone,
  output logic       illegalOp
);

  always_comb begin
    pcWrite   = 1'b0;
    irWrite   = 1'b0;
    iOrD      = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    regDst    = 1'b0;
    regWrite  = 1'b0;
    memToReg  = 1'b0;
    aluSrcA   = 1'b0;
    aluSrcB   = SRCB_RT;
    aluOp     = ALU_ADD;
    branch    = 1'b0;
    branchNot = 1'b0;
    instrDone = 1'b0;
    illegalOp = 1'b0;
    case (state)
      FETCH: begin
        memRead = 1'b1;
        aluSrcB = SRCB_ONE;
        irWrite = memReady;
        pcWrite = memReady;
      end
      DECODE: begin
        aluSrcB   = SRCB_IMM;
        illegalOp = decodeIllegal;
      end
      EXEC_R: begin
        aluSrcA = 1'b1;
        aluOp   = ALU_FUNCT;
      end
      EXEC_I: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
        aluOp   = {1'b1, ialuCode};
      end
      MEM_ADDR: begin
        aluSrcA = 1'b1;
        aluSrcB = SRCB_IMM;
      end
      MEM_RD: begin
        iOrD    = 1'b1;
        memRead = 1'b1;
      end
      MEM_WB: begin
        regWrite  = 1'b1;
        memToReg  = 1'b1;
        instrDone = 1'b1;
      end
      MEM_WR: begin
        iOrD      = 1'b1;
        memWrite  = 1'b1;
        instrDone = memReady;
      end
      ALU_WB: begin
        regWrite  = 1'b1;
        regDst    = isRtype;
        instrDone = 1'b1;
      end
      BRANCH: begin
        aluSrcA   = 1'b1;
        aluOp     = ALU_SUB;
        branch    = ~isBne;
        branchNot = isBne;
        instrDone = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_main_control.sv
// MiniMips multi-cycle main control: state register, next-state logic and
// opcode-derived flags captured in DECODE; outputs come from mc_output_decode.
module multicycle_main_control
  import minimips_ctrl_pkg::*;
#(
  parameter int              OP_W       = 4,
  parameter logic [OP_W-1:0] OP_RTYPE   = OP_W'(4'b0000),
  parameter logic [OP_W-1:0] OP_IALU_LO = OP_W'(4'b0001),
  parameter logic [OP_W-1:0] OP_IALU_HI = OP_W'(4'b0100),
  parameter logic [OP_W-1:0] OP_BEQ     = OP_W'(4'b0101),
  parameter logic [OP_W-1:0] OP_BNE     = OP_W'(4'b0110),
  parameter logic [OP_W-1:0] OP_LW      = OP_W'(4'b1000),
  parameter logic [OP_W-1:0] OP_SW      = OP_W'(4'b1001)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [OP_W-1:0] op,
  input  logic            mem_ready,
  output logic            pc_write,
  output logic            ir_write,
  output logic            i_or_d,
  output logic            mem_read,
  output logic            mem_write,
  output logic            reg_dst,
  output logic            reg_write,
  output logic            mem_to_reg,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [2:0]      alu_op,
  output logic            branch,
  output logic            branch_not,
  output logic            instr_done,
  output logic            illegal_op,
  output logic [3:0]      state
);

  mcState_t   curState, nextState;
  logic       isRtype, isBne, isSw;
  logic [1:0] ialuCode;

  logic       opRtype, opIalu, opBranch, opMem, opLegal;
  logic [1:0] ialuCodeNext;

  always_comb begin
    opRtype      = (op == OP_RTYPE);
    opIalu       = (op >= OP_IALU_LO) && (op <= OP_IALU_HI);
    opBranch     = (op == OP_BEQ) || (op == OP_BNE);
    opMem        = (op == OP_LW) || (op == OP_SW);
    opLegal      = opRtype || opIalu || opBranch || opMem;
    ialuCodeNext = 2'(op - OP_IALU_LO);
  end

  always_comb begin
    nextState = FETCH;
    case (curState)
      FETCH:    nextState = mem_ready ? DECODE : FETCH;
      DECODE: begin
        if (opRtype)       nextState = EXEC_R;
        else if (opIalu)   nextState = EXEC_I;
        else if (opBranch) nextState = BRANCH;
        else if (opMem)    nextState = MEM_ADDR;
        else               nextState = FETCH;
      end
      EXEC_R:   nextState = ALU_WB;
      EXEC_I:   nextState = ALU_WB;
      MEM_ADDR: nextState = isSw ? MEM_WR : MEM_RD;
      MEM_RD:   nextState = mem_ready ? MEM_WB : MEM_RD;
      MEM_WR:   nextState = mem_ready ? FETCH : MEM_WR;
      default:  nextState = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      curState <= FETCH;
      isRtype  <= 1'b0;
      isBne    <= 1'b0;
      isSw     <= 1'b0;
      ialuCode <= '0;
    end else begin
      curState <= nextState;
      // Flags latch only in DECODE so later op changes cannot disturb the instruction.
      if (curState == DECODE) begin
        isRtype  <= opRtype;
        isBne    <= (op == OP_BNE);
        isSw     <= (op == OP_SW);
        ialuCode <= ialuCodeNext;
      end
    end
  end

  assign state = curState;

  mc_output_decode uDecode (
    .state         (curState),
    .isRtype       (isRtype),
    .isBne         (isBne),
    .ialuCode      (ialuCode),
    .memReady      (mem_ready),
    .decodeIllegal (~opLegal),
    .pcWrite       (pc_write),
    .irWrite       (ir_write),
    .iOrD          (i_or_d),
    .memRead       (mem_read),
    .memWrite      (mem_write),
    .regDst        (reg_dst),
    .regWrite      (reg_write),
    .memToReg      (mem_to_reg),
    .aluSrcA       (alu_src_a),
    .aluSrcB       (alu_src_b),
    .aluOp         (alu_op),
    .branch        (branch),
    .branchNot     (branch_not),
    .instrDone     (instr_done),
    .illegalOp     (illegal_op)
  );

endmodule

// File: tb/tb_multicycle_main_control.sv
// Directed bench for multicycle_main_control: walks each instruction class
// cycle by cycle and checks state plus the full packed control vector.
module tb_multicycle_main_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] op;
  logic       mem_ready;
  logic       pc_write, ir_write, i_or_d, mem_read, mem_write;
  logic       reg_dst, reg_write, mem_to_reg, alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic       branch, branch_not, instr_done, illegal_op;
  logic [3:0] state;

  int nAsserts = 0;
  int nFails   = 0;

  multicycle_main_control #(.OP_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_dst    (reg_dst),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .branch     (branch),
    .branch_not (branch_not),
    .instr_done (instr_done),
    .illegal_op (illegal_op),
    .state      (state)
  );

  always #5 clk = ~clk;

  // Field order: pw iw iod mr mw rd rw m2r asa asb[1:0] aop[2:0] br bn done ill
  logic [17:0] ctl;
  assign ctl = {pc_write, ir_write, i_or_d, mem_read, mem_write, reg_dst, reg_write,
                mem_to_reg, alu_src_a, alu_src_b, alu_op, branch, branch_not,
                instr_done, illegal_op};

  localparam logic [17:0] C_FETCH_RDY  = 18'b1_1_0_1_0_0_0_0_0_01_000_0_0_0_0;
  localparam logic [17:0] C_FETCH_WAIT = 18'b0_0_0_1_0_0_0_0_0_01_000_0_0_0_0;
  localparam logic [17:0] C_DECODE     = 18'b0_0_0_0_0_0_0_0_0_10_000_0_0_0_0;
  localparam logic [17:0] C_DECODE_ILL = 18'b0_0_0_0_0_0_0_0_0_10_000_0_0_0_1;
  localparam logic [17:0] C_EXEC_R     = 18'b0_0_0_0_0_0_0_0_1_00_010_0_0_0_0;
  localparam logic [17:0] C_EXEC_I3    = 18'b0_0_0_0_0_0_0_0_1_10_110_0_0_0_0;
  localparam logic [17:0] C_WB_R       = 18'b0_0_0_0_0_1_1_0_0_00_000_0_0_1_0;
  localparam logic [17:0] C_WB_I       = 18'b0_0_0_0_0_0_1_0_0_00_000_0_0_1_0;
  localparam logic [17:0] C_MEM_ADDR   = 18'b0_0_0_0_0_0_0_0_1_10_000_0_0_0_0;
  localparam logic [17:0] C_MEM_RD     = 18'b0_0_1_1_0_0_0_0_0_00_000_0_0_0_0;
  localparam logic [17:0] C_MEM_WB     = 18'b0_0_0_0_0_0_1_1_0_00_000_0_0_1_0;
  localparam logic [17:0] C_MEM_WR     = 18'b0_0_1_0_1_0_0_0_0_00_000_0_0_0_0;
  localparam logic [17:0] C_MEM_WR_RDY = 18'b0_0_1_0_1_0_0_0_0_00_000_0_0_1_0;
  localparam logic [17:0] C_BEQ        = 18'b0_0_0_0_0_0_0_0_1_00_001_1_0_1_0;
  localparam logic [17:0] C_BNE        = 18'b0_0_0_0_0_0_0_0_1_00_001_0_1_1_0;

  task automatic chk(input string tag, input logic [17:0] got, input logic [17:0] exp);
    nAsserts++;
    assert (got === exp) else begin
      nFails++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  // Check the current cycle mid-period, then advance to 2 time units past the next edge.
  task automatic step(input string tag, input logic [3:0] expState, input logic [17:0] expCtl);
    #1;
    chk({tag, ".state"}, {14'd0, state}, {14'd0, expState});
    chk({tag, ".ctl"}, ctl, expCtl);
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; op = 4'b0000; mem_ready = 1'b0;
    #3;
    chk("reset.state", {14'd0, state}, 18'd0);
    chk("reset.ctl", ctl, C_FETCH_WAIT);
    #4 rst_n = 1'b1;

    // R-type: 0,1,2,8
    op = 4'b0000; mem_ready = 1'b1;
    step("r.fetch",  4'd0, C_FETCH_RDY);
    step("r.decode", 4'd1, C_DECODE);
    step("r.exec",   4'd2, C_EXEC_R);
    step("r.wb",     4'd8, C_WB_R);

    // I-type op=0011, op changed after DECODE must not matter
    op = 4'b0011;
    step("i.fetch",  4'd0, C_FETCH_RDY);
    step("i.decode", 4'd1, C_DECODE);
    op = 4'b0000;
    step("i.exec",   4'd3, C_EXEC_I3);
    step("i.wb",     4'd8, C_WB_I);

    // LW with 2 FETCH waits and 3 MEM_RD waits: 10 cycles
    op = 4'b1000; mem_ready = 1'b0;
    step("lw.fwait0", 4'd0, C_FETCH_WAIT);
    step("lw.fwait1", 4'd0, C_FETCH_WAIT);
    mem_ready = 1'b1;
    step("lw.fetch",  4'd0, C_FETCH_RDY);
    mem_ready = 1'b0;
    step("lw.decode", 4'd1, C_DECODE);
    step("lw.addr",   4'd4, C_MEM_ADDR);
    step("lw.rwait0", 4'd5, C_MEM_RD);
    step("lw.rwait1", 4'd5, C_MEM_RD);
    step("lw.rwait2", 4'd5, C_MEM_RD);
    mem_ready = 1'b1;
    step("lw.rd",     4'd5, C_MEM_RD);
    step("lw.wb",     4'd6, C_MEM_WB);

    // BEQ then BNE
    op = 4'b0101;
    step("beq.fetch",  4'd0, C_FETCH_RDY);
    step("beq.decode", 4'd1, C_DECODE);
    step("beq.branch", 4'd9, C_BEQ);
    op = 4'b0110;
    step("bne.fetch",  4'd0, C_FETCH_RDY);
    step("bne.decode", 4'd1, C_DECODE);
    step("bne.branch", 4'd9, C_BNE);

    // Illegal opcode, then a normal R-type fetch
    op = 4'b1111;
    step("ill.fetch",  4'd0, C_FETCH_RDY);
    step("ill.decode", 4'd1, C_DECODE_ILL);
    op = 4'b0000;
    step("ill.refetch", 4'd0, C_FETCH_RDY);
    step("ill.decode2", 4'd1, C_DECODE);
    step("ill.exec",    4'd2, C_EXEC_R);
    step("ill.wb",      4'd8, C_WB_R);

    // SW aborted by asynchronous reset mid-write
    op = 4'b1001;
    step("swa.fetch",  4'd0, C_FETCH_RDY);
    step("swa.decode", 4'd1, C_DECODE);
    mem_ready = 1'b0;
    step("swa.addr",   4'd4, C_MEM_ADDR);
    step("swa.wr0",    4'd7, C_MEM_WR);
    #1;
    chk("swa.wr1.state", {14'd0, state}, 18'd7);
    chk("swa.wr1.ctl", ctl, C_MEM_WR);
    rst_n = 1'b0;
    #1;
    chk("swa.rst.state", {14'd0, state}, 18'd0);
    chk("swa.rst.ctl", ctl, C_FETCH_WAIT);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #2;
    step("swa.after", 4'd0, C_FETCH_WAIT);

    // Complete SW with mem_ready high: 4 cycles
    mem_ready = 1'b1;
    step("sw.fetch",  4'd0, C_FETCH_RDY);
    step("sw.decode", 4'd1, C_DECODE);
    step("sw.addr",   4'd4, C_MEM_ADDR);
    step("sw.wr",     4'd7, C_MEM_WR_RDY);
    step("sw.next",   4'd0, C_FETCH_RDY);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
